bus_ack_gen: RTL and testbench
==============================

// Module: bus_ack_gen
// PURPOSE
//   Pipelined bus acknowledge generator for slave devices (config space, peripherals).
//   Read and write requests enter separate delay lines of configurable depth; the
//   outputs merge into a single ack plus the matching read/write transaction IDs.
//   Models fixed-latency slaves, e.g. BRAM reads with registered output muxing.
// PARAMETERS
//   READ_STAGES      3   read ack latency in register stages, legal 1..16
//   WRITE_STAGES     1   write ack latency in register stages, legal 1..16
//   REGISTER_OUTPUT  1   1 = extra output register on o/rid_o/wid_o; 0 = combinational merge
//   TID_W            13  transaction ID width; defaults to $bits(wb_tranid_t)
// PORTS
//   clk_i    in   1      sole clock, rising edge
//   rst_i    in   1      reset, asynchronous assert, active-low
//   ce_i     in   1      clock enable; 0 freezes every pipeline and output register
//   i        in   1      read request strobe, one request per cycle sampled high
//   we_i     in   1      write request strobe, one request per cycle sampled high
//   rid_i    in   TID_W  read transaction ID, sampled with i
//   wid_i    in   TID_W  write transaction ID, sampled with we_i
//   o        out  1      acknowledge, read or write
//   rid_o    out  TID_W  ID of the read being acked, 0 when no read ack
//   wid_o    out  TID_W  ID of the write being acked, 0 when no write ack
// BEHAVIOUR
//   Reset: clock and reset are fixed as one clock; reset is asynchronous and active-low.
//     While rst_i=0, all pipeline stages clear and o=0, rid_o=0, wid_o=0, regardless of ce_i.
//   Each rising edge with ce_i=1 shifts both delay lines by one stage.
//     Read line stage 0 loads {i, rid_i}; write line stage 0 loads {we_i, wid_i}.
//   Latency is counted from the edge that samples the request.
//     Read: o is high READ_STAGES edges later, plus 1 if REGISTER_OUTPUT=1.
//     Write: o is high WRITE_STAGES edges later, plus 1 if REGISTER_OUTPUT=1.
//   Pulse width: each sampled request cycle yields exactly one ack cycle.
//     A strobe held N cycles yields N consecutive ack cycles. There is no handshake or backpressure.
//   Merge: o = read_tail.v | write_tail.v.
//     rid_o = read_tail.v ? read_tail.id : 0; wid_o = write_tail.v ? write_tail.id : 0.
//   Simultaneous read and write tails: o=1 once, and rid_o and wid_o are both valid.
//   i and we_i high in the same cycle are legal; each is tracked independently.
//   ce_i=0: state holds and outputs hold their last value. Requests presented during the stall are dropped.
//   Reset mid-operation flushes all in-flight acks; no ack is emitted for them after reset releases.
//   No state machine is used; the block is pure shift pipelines.
// CONFIGURATION
//   ACK_GEN_TID_EN defined: rid/wid pipelines are built as described above.
//   ACK_GEN_TID_EN undefined: ID pipelines are omitted, rid_o/wid_o are tied to 0, and rid_i/wid_i are ignored.
//     o timing is identical in both builds.
// STRUCTURE
//   Shared package (wishbone_pkg): wb_tranid_t and the default TID_W.
//     Stage-limit constant ACK_GEN_MAX_STAGES=16 also lives there.
//   Sub-module ack_dly_line #(DEP, W): reset/CE-aware shift register of {valid, id}.
//     Instantiated once for the read path and once for the write path.
//   Top level: output merge and optional output register only.
// TESTING (READ_STAGES=3, WRITE_STAGES=1, REGISTER_OUTPUT=1, TID_W=13, ACK_GEN_TID_EN set)
//   Single read: i=1, rid_i=0x05 sampled at edge 0 -> o=1, rid_o=0x05 only after edge 4; wid_o=0.
//   Single write: we_i=1, wid_i=0x1A at edge 0 -> o=1, wid_o=0x1A only after edge 2; rid_o=0.
//   Back-to-back: i held 3 cycles with IDs 1,2,3 -> o high 3 cycles after edges 4,5,6, rid_o=1,2,3.
//   Collision: read at edge 0 and write (wid 0x7) at edge 2 -> after edge 4 o=1 once.
//     rid_o and wid_o are both valid in that cycle.
//   Stall: read at edge 0, ce_i=0 for 2 cycles from edge 1 -> ack delayed to after edge 6; single pulse.
//   Reset: read at edge 0, rst_i=0 asynchronously at cycle 2 -> o/rid_o/wid_o=0 at once and no ack after release.

Source files
------------

// File: rtl/wishbone_pkg.sv
// Shared bus definitions for the Wishbone-side slave helpers.
// Holds the transaction ID type, the default ID width derived from it and
// the depth limit that every acknowledge delay line is built against.
package wishbone_pkg;

    // Transaction ID carried alongside each request through the ack pipelines.
    typedef logic [12:0] wb_tranid_t;

    // Default ID width follows the ID type so both stay in step when it changes.
    localparam int WB_TID_W = $bits(wb_tranid_t);

    // Deepest delay line an ack generator may be configured with.
    localparam int ACK_GEN_MAX_STAGES = 16;

    // Smallest legal delay line depth.
    localparam int ACK_GEN_MIN_STAGES = 1;

endpackage

// File: rtl/ack_dly_line.sv
// Acknowledge delay line: a reset- and clock-enable-aware shift register of
// {valid, id} pairs. Stage 0 is the sampling register for the incoming request;
// the DEP stages behind it set the latency, so the tail carries a request DEP
// enabled edges after the edge that sampled it.
// With HAS_ID = 0 only the valid bits are stored and the id output is tied to 0.
module ack_dly_line
    import wishbone_pkg::*;
#(
    parameter int DEP    = 1,
    parameter int W      = WB_TID_W,
    parameter bit HAS_ID = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         ce_i,
    input  logic         v_in,
    input  logic [W-1:0] id_in,
    output logic         v_out,
    output logic [W-1:0] id_out
);

    // One valid bit per stage, index 0 nearest the input.
    logic [DEP:0] v_q;

    // Shift the valid bits on every enabled edge; reset empties the whole line.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            v_q <= '0;
        end else if (ce_i) begin
            v_q <= {v_q[DEP-1:0], v_in};
        end
    end

    assign v_out = v_q[DEP];

    generate
        if (HAS_ID) begin : g_id
            logic [W-1:0] id_q [0:DEP];

            // Shift the IDs in lockstep with their valid bits.
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    for (int k = 0; k <= DEP; k++) begin
                        id_q[k] <= '0;
                    end
                end else if (ce_i) begin
                    id_q[0] <= id_in;
                    for (int k = 1; k <= DEP; k++) begin
                        id_q[k] <= id_q[k-1];
                    end
                end
            end

            assign id_out = id_q[DEP];
        end else begin : g_no_id
            logic unused_id;

            assign unused_id = ^id_in;
            assign id_out    = '0;
        end
    endgenerate

endmodule

// File: rtl/bus_ack_gen.sv
// Pipelined bus acknowledge generator for fixed-latency slaves.
// Read and write requests travel through separate delay lines; their tails are
// merged into a single ack plus the read and write IDs being acknowledged,
// optionally through one more output register.
// Configuration macro: ACK_GEN_TID_EN. When defined the read/write ID pipelines
// are built; when undefined only the valid bits are delayed, rid_o/wid_o stay 0
// and rid_i/wid_i are ignored. Ack timing is identical in both builds.
// Legal depths for READ_STAGES/WRITE_STAGES are 1..ACK_GEN_MAX_STAGES.
module bus_ack_gen
    import wishbone_pkg::*;
#(
    parameter int READ_STAGES     = 3,
    parameter int WRITE_STAGES    = 1,
    parameter int REGISTER_OUTPUT = 1,
    parameter int TID_W           = WB_TID_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ce_i,
    input  logic             i,
    input  logic             we_i,
    input  logic [TID_W-1:0] rid_i,
    input  logic [TID_W-1:0] wid_i,
    output logic             o,
    output logic [TID_W-1:0] rid_o,
    output logic [TID_W-1:0] wid_o
);

`ifdef ACK_GEN_TID_EN
    localparam bit IDS_EN = 1'b1;
`else
    localparam bit IDS_EN = 1'b0;
`endif

    logic             rd_tail_v;
    logic [TID_W-1:0] rd_tail_id;
    logic             wr_tail_v;
    logic [TID_W-1:0] wr_tail_id;

    logic             merge_ack;
    logic [TID_W-1:0] merge_rid;
    logic [TID_W-1:0] merge_wid;

    ack_dly_line #(
        .DEP    (READ_STAGES),
        .W      (TID_W),
        .HAS_ID (IDS_EN)
    ) u_rd_line (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .ce_i   (ce_i),
        .v_in   (i),
        .id_in  (rid_i),
        .v_out  (rd_tail_v),
        .id_out (rd_tail_id)
    );

    ack_dly_line #(
        .DEP    (WRITE_STAGES),
        .W      (TID_W),
        .HAS_ID (IDS_EN)
    ) u_wr_line (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .ce_i   (ce_i),
        .v_in   (we_i),
        .id_in  (wid_i),
        .v_out  (wr_tail_v),
        .id_out (wr_tail_id)
    );

    // Merge both tails into one ack; each ID is shown only while its own tail is valid.
    always_comb begin
        merge_ack = rd_tail_v | wr_tail_v;
        merge_rid = '0;
        merge_wid = '0;
        if (rd_tail_v) begin
            merge_rid = rd_tail_id;
        end
        if (wr_tail_v) begin
            merge_wid = wr_tail_id;
        end
    end

    generate
        if (REGISTER_OUTPUT != 0) begin : g_out_reg
            // Register the merged ack so the slave sees clean flop outputs; frozen by ce_i.
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    o     <= 1'b0;
                    rid_o <= '0;
                    wid_o <= '0;
                end else if (ce_i) begin
                    o     <= merge_ack;
                    rid_o <= merge_rid;
                    wid_o <= merge_wid;
                end
            end
        end else begin : g_out_comb
            assign o     = merge_ack;
            assign rid_o = merge_rid;
            assign wid_o = merge_wid;
        end
    endgenerate

endmodule

// File: tb/tb_bus_ack_gen.sv
// Self-checking bench for bus_ack_gen (READ_STAGES=3, WRITE_STAGES=1,
// REGISTER_OUTPUT=1, TID_W=13). Expected IDs are zero unless ACK_GEN_TID_EN
// is defined, matching the build under test.
module tb_bus_ack_gen;

    localparam int RS    = 3;
    localparam int WS    = 1;
    localparam int RO    = 1;
    localparam int TID_W = 13;
    localparam int LR    = RS + RO;
    localparam int LW    = WS + RO;
    localparam int HMAX  = 1024;

    logic             clk_i;
    logic             rst_i;
    logic             ce_i;
    logic             i;
    logic             we_i;
    logic [TID_W-1:0] rid_i;
    logic [TID_W-1:0] wid_i;
    logic             o;
    logic [TID_W-1:0] rid_o;
    logic [TID_W-1:0] wid_o;

    int tests_run;
    int tests_failed;
    bit cmp_en;

    // Model history: what was sampled on each enabled edge since reset released.
    bit               h_rv  [0:HMAX-1];
    logic [TID_W-1:0] h_rid [0:HMAX-1];
    bit               h_wv  [0:HMAX-1];
    logic [TID_W-1:0] h_wid [0:HMAX-1];
    int               h_n;

    bus_ack_gen #(
        .READ_STAGES     (RS),
        .WRITE_STAGES    (WS),
        .REGISTER_OUTPUT (RO),
        .TID_W           (TID_W)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .ce_i  (ce_i),
        .i     (i),
        .we_i  (we_i),
        .rid_i (rid_i),
        .wid_i (wid_i),
        .o     (o),
        .rid_o (rid_o),
        .wid_o (wid_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // IDs only reach the outputs in the build with the ID pipelines.
    function automatic logic [TID_W-1:0] tid(input logic [TID_W-1:0] x);
`ifdef ACK_GEN_TID_EN
        return x;
`else
        return '0;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic eo,
                               input logic [TID_W-1:0] erid, input logic [TID_W-1:0] ewid);
        tests_run++;
        if (o !== eo || rid_o !== erid || wid_o !== ewid) begin
            tests_failed++;
            $display("[TB] FAIL %s at %0t: got o=%b rid_o=0x%0h wid_o=0x%0h, expected o=%b rid_o=0x%0h wid_o=0x%0h",
                     name, $time, o, rid_o, wid_o, eo, erid, ewid);
        end
    endtask

    // One clock edge with the given inputs; returns just after that edge.
    task automatic applyStimulus(input logic rd, input logic [TID_W-1:0] rid,
                                 input logic wr, input logic [TID_W-1:0] wid,
                                 input logic ce);
        i     = rd;
        rid_i = rid;
        we_i  = wr;
        wid_i = wid;
        ce_i  = ce;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        end
    endtask

    // Record every enabled edge; an ack is due LR / LW enabled edges after its request.
    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            h_n = 0;
        end else if (ce_i && h_n < HMAX) begin
            h_rv[h_n]  = i;
            h_rid[h_n] = rid_i;
            h_wv[h_n]  = we_i;
            h_wid[h_n] = wid_i;
            h_n++;
        end
    end

    // Compare the DUT against the history model on every falling edge.
    always @(negedge clk_i) begin
        if (cmp_en) begin
            int               m;
            logic             er;
            logic             ew;
            logic [TID_W-1:0] erid;
            logic [TID_W-1:0] ewid;
            m    = h_n - 1;
            er   = 1'b0;
            ew   = 1'b0;
            erid = '0;
            ewid = '0;
            if (m - LR >= 0 && h_rv[m-LR]) begin
                er   = 1'b1;
                erid = tid(h_rid[m-LR]);
            end
            if (m - LW >= 0 && h_wv[m-LW]) begin
                ew   = 1'b1;
                ewid = tid(h_wid[m-LW]);
            end
            checkOutput("model", er | ew, erid, ewid);
        end
    end

    typedef struct packed {
        logic             rd;
        logic [TID_W-1:0] rid;
        logic             wr;
        logic [TID_W-1:0] wid;
        logic             ce;
    } vec_t;

    vec_t mix [0:15];

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        cmp_en       = 1'b0;
        h_n          = 0;
        rst_i        = 1'b0;
        ce_i         = 1'b1;
        i            = 1'b0;
        we_i         = 1'b0;
        rid_i        = '0;
        wid_i        = '0;

        mix[0]  = '{1'b1, 13'h0101, 1'b0, 13'h0000, 1'b1};
        mix[1]  = '{1'b1, 13'h0102, 1'b1, 13'h0201, 1'b1};
        mix[2]  = '{1'b0, 13'h0000, 1'b1, 13'h0202, 1'b1};
        mix[3]  = '{1'b1, 13'h0103, 1'b1, 13'h0203, 1'b0};
        mix[4]  = '{1'b1, 13'h0104, 1'b0, 13'h0000, 1'b1};
        mix[5]  = '{1'b0, 13'h0000, 1'b0, 13'h0000, 1'b1};
        mix[6]  = '{1'b0, 13'h0000, 1'b1, 13'h1FFF, 1'b1};
        mix[7]  = '{1'b1, 13'h1FFF, 1'b0, 13'h0000, 1'b0};
        mix[8]  = '{1'b1, 13'h1ABC, 1'b1, 13'h0ABC, 1'b1};
        mix[9]  = '{1'b0, 13'h0000, 1'b0, 13'h0000, 1'b0};
        mix[10] = '{1'b1, 13'h0105, 1'b0, 13'h0000, 1'b1};
        mix[11] = '{1'b1, 13'h0106, 1'b1, 13'h0204, 1'b1};
        mix[12] = '{1'b0, 13'h0000, 1'b1, 13'h0205, 1'b1};
        mix[13] = '{1'b0, 13'h0000, 1'b0, 13'h0000, 1'b0};
        mix[14] = '{1'b0, 13'h0000, 1'b0, 13'h0000, 1'b1};
        mix[15] = '{1'b1, 13'h0107, 1'b1, 13'h0206, 1'b1};

        // Reset state, with requests and ce_i toggling to show reset dominates.
        @(posedge clk_i);
        #1;
        i    = 1'b1;
        we_i = 1'b1;
        ce_i = 1'b0;
        @(posedge clk_i);
        #1;
        checkOutput("reset_state", 1'b0, '0, '0);
        i    = 1'b0;
        we_i = 1'b0;
        ce_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i  = 1'b1;
        cmp_en = 1'b1;
        idle(2);

        // Single read: sampled at edge 0, ack only after edge 4.
        applyStimulus(1'b1, 13'h05, 1'b0, '0, 1'b1);
        idle(3);
        checkOutput("rd_early", 1'b0, '0, '0);
        idle(1);
        checkOutput("rd_ack", 1'b1, tid(13'h05), '0);
        idle(1);
        checkOutput("rd_single", 1'b0, '0, '0);
        idle(4);

        // Single write: sampled at edge 0, ack only after edge 2.
        applyStimulus(1'b0, '0, 1'b1, 13'h1A, 1'b1);
        idle(1);
        checkOutput("wr_early", 1'b0, '0, '0);
        idle(1);
        checkOutput("wr_ack", 1'b1, '0, tid(13'h1A));
        idle(1);
        checkOutput("wr_single", 1'b0, '0, '0);
        idle(4);

        // Back-to-back reads with IDs 1,2,3.
        applyStimulus(1'b1, 13'h1, 1'b0, '0, 1'b1);
        applyStimulus(1'b1, 13'h2, 1'b0, '0, 1'b1);
        applyStimulus(1'b1, 13'h3, 1'b0, '0, 1'b1);
        idle(2);
        checkOutput("b2b_1", 1'b1, tid(13'h1), '0);
        idle(1);
        checkOutput("b2b_2", 1'b1, tid(13'h2), '0);
        idle(1);
        checkOutput("b2b_3", 1'b1, tid(13'h3), '0);
        idle(1);
        checkOutput("b2b_end", 1'b0, '0, '0);
        idle(4);

        // Collision: read at edge 0, write at edge 2, both tails land after edge 4.
        applyStimulus(1'b1, 13'h11, 1'b0, '0, 1'b1);
        idle(1);
        applyStimulus(1'b0, '0, 1'b1, 13'h7, 1'b1);
        idle(2);
        checkOutput("collide", 1'b1, tid(13'h11), tid(13'h7));
        idle(1);
        checkOutput("collide_end", 1'b0, '0, '0);
        idle(4);

        // Stall: two frozen edges push the ack to after edge 6; stalled requests drop.
        applyStimulus(1'b1, 13'h22, 1'b0, '0, 1'b1);
        applyStimulus(1'b1, 13'h33, 1'b1, 13'h44, 1'b0);
        applyStimulus(1'b1, 13'h55, 1'b0, '0, 1'b0);
        idle(3);
        checkOutput("stall_early", 1'b0, '0, '0);
        idle(1);
        checkOutput("stall_ack", 1'b1, tid(13'h22), '0);
        idle(1);
        checkOutput("stall_single", 1'b0, '0, '0);
        idle(6);

        // Stall while an ack is showing: outputs hold their last value.
        applyStimulus(1'b0, '0, 1'b1, 13'h0C, 1'b1);
        idle(2);
        checkOutput("hold_pre", 1'b1, '0, tid(13'h0C));
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        checkOutput("hold_frozen", 1'b1, '0, tid(13'h0C));
        idle(1);
        checkOutput("hold_end", 1'b0, '0, '0);
        idle(4);

        // Reset mid-operation: write ack showing, read still in flight.
        applyStimulus(1'b1, 13'h44, 1'b1, 13'h2B, 1'b1);
        idle(2);
        checkOutput("rst_pre", 1'b1, '0, tid(13'h2B));
        #2;
        rst_i = 1'b0;
        ce_i  = 1'b0;
        #1;
        checkOutput("rst_async", 1'b0, '0, '0);
        @(posedge clk_i);
        #1;
        checkOutput("rst_hold", 1'b0, '0, '0);
        rst_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            idle(1);
            checkOutput("rst_flush", 1'b0, '0, '0);
        end

        // Mixed traffic with simultaneous strobes and stalls, checked by the model.
        for (int k = 0; k < 16; k++) begin
            applyStimulus(mix[k].rd, mix[k].rid, mix[k].wr, mix[k].wid, mix[k].ce);
        end
        idle(8);
        checkOutput("drained", 1'b0, '0, '0);

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
